// File: rtl/gen_sequencer_pkg.sv
// Shared types and widths for the burst generator sequencer.
package gen_sequencer_pkg;

    localparam int unsigned CYC_W = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TOT_W = 48;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [CYC_W-1:0] burst_cycles;
        logic [CNT_W-1:0] burst_count;
        logic [CNT_W-1:0] gap_cycles;
    } seq_cfg_t;

endpackage

// File: rtl/gen_sequencer.sv
// Sequences bursts of a stream generator and counts observed beats.
// Optional RUN-state watchdog enabled by defining GEN_SEQUENCER_TIMEOUT_EN.
module gen_sequencer
    import gen_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [CYC_W-1:0] cfg_burst_cycles,
    input  logic [CNT_W-1:0] cfg_burst_count,
    input  logic [CNT_W-1:0] cfg_gap_cycles,
    output logic             gen_start,
    output logic [CYC_W-1:0] gen_max_cycles,
    input  logic             mon_tvalid,
    input  logic             mon_tready,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             error,
    output logic [CNT_W-1:0] bursts_done,
    output logic [TOT_W-1:0] beats_total
);

    seq_state_t       state, state_nxt;
    seq_cfg_t         cfg_q, cfg_nxt;
    logic [CYC_W-1:0] beat_cnt, beat_cnt_nxt, beat_cnt_inc;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [CNT_W-1:0] bursts_nxt, bursts_inc;
    logic [TOT_W-1:0] total_nxt;
    logic             aborted_nxt;
    logic             beat_c;

`ifdef GEN_SEQUENCER_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [WD_W-1:0] wdog, wdog_nxt;
    logic            error_nxt;
`endif

    assign beat_c         = mon_tvalid & mon_tready;
    assign beat_cnt_inc   = beat_cnt + CYC_W'(1);
    assign bursts_inc     = bursts_done + CNT_W'(1);
    assign gen_max_cycles = cfg_q.burst_cycles;

    // Next-state and next-counter logic; abort overrides everything at the end.
    always_comb begin
        state_nxt    = state;
        cfg_nxt      = cfg_q;
        beat_cnt_nxt = beat_cnt;
        gap_cnt_nxt  = gap_cnt;
        bursts_nxt   = bursts_done;
        total_nxt    = beats_total;
        aborted_nxt  = aborted;
`ifdef GEN_SEQUENCER_TIMEOUT_EN
        wdog_nxt     = wdog;
        error_nxt    = error;
`endif
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    cfg_nxt.burst_cycles = cfg_burst_cycles;
                    cfg_nxt.burst_count  = cfg_burst_count;
                    cfg_nxt.gap_cycles   = cfg_gap_cycles;
                    bursts_nxt           = '0;
                    total_nxt            = '0;
                    aborted_nxt          = 1'b0;
`ifdef GEN_SEQUENCER_TIMEOUT_EN
                    error_nxt            = 1'b0;
`endif
                    state_nxt = (cfg_burst_cycles == '0 || cfg_burst_count == '0)
                              ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                beat_cnt_nxt = '0;
`ifdef GEN_SEQUENCER_TIMEOUT_EN
                wdog_nxt     = '0;
`endif
                state_nxt    = ST_RUN;
            end
            ST_RUN: begin
                if (beat_c) begin
                    beat_cnt_nxt = beat_cnt_inc;
                    total_nxt    = beats_total + TOT_W'(1);
`ifdef GEN_SEQUENCER_TIMEOUT_EN
                    wdog_nxt     = '0;
`endif
                    if (beat_cnt_inc == cfg_q.burst_cycles) begin
                        bursts_nxt  = bursts_inc;
                        gap_cnt_nxt = '0;
                        state_nxt   = (bursts_inc == cfg_q.burst_count) ? ST_DONE : ST_GAP;
                    end
                end
`ifdef GEN_SEQUENCER_TIMEOUT_EN
                else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                end
`endif
            end
            ST_GAP: begin
                // A zero gap still spends one cycle here before relaunching.
                if (cfg_q.gap_cycles == '0 || gap_cnt == cfg_q.gap_cycles - CNT_W'(1)) begin
                    state_nxt = ST_LAUNCH;
                end else begin
                    gap_cnt_nxt = gap_cnt + CNT_W'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if (cfg_abort && state != ST_IDLE) begin
            state_nxt    = ST_IDLE;
            aborted_nxt  = 1'b1;
            beat_cnt_nxt = beat_cnt;
            gap_cnt_nxt  = gap_cnt;
            bursts_nxt   = bursts_done;
            total_nxt    = beats_total;
`ifdef GEN_SEQUENCER_TIMEOUT_EN
            error_nxt    = error;
`endif
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            cfg_q       <= '0;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            bursts_done <= '0;
            beats_total <= '0;
            aborted     <= 1'b0;
            gen_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_q       <= cfg_nxt;
            beat_cnt    <= beat_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            bursts_done <= bursts_nxt;
            beats_total <= total_nxt;
            aborted     <= aborted_nxt;
            gen_start   <= (state_nxt == ST_LAUNCH);
            busy        <= (state_nxt != ST_IDLE);
            done        <= (state_nxt == ST_DONE);
        end
    end

`ifdef GEN_SEQUENCER_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdog  <= '0;
            error <= 1'b0;
        end else begin
            wdog  <= wdog_nxt;
            error <= error_nxt;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_gen_sequencer.sv
// Randomized bench for gen_sequencer against a count-down behavioural model.
// Watchdog scenario active when GEN_SEQUENCER_TIMEOUT_EN is defined.
module tb_gen_sequencer;

`ifdef GEN_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk;
    logic        resetn;
    logic        cfg_start, cfg_abort;
    logic [31:0] cfg_burst_cycles;
    logic [15:0] cfg_burst_count, cfg_gap_cycles;
    logic        gen_start;
    logic [31:0] gen_max_cycles;
    logic        mon_tvalid, mon_tready;
    logic        busy, done, aborted, error;
    logic [15:0] bursts_done;
    logic [47:0] beats_total;

    gen_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_burst_cycles(cfg_burst_cycles), .cfg_burst_count(cfg_burst_count),
        .cfg_gap_cycles(cfg_gap_cycles),
        .gen_start(gen_start), .gen_max_cycles(gen_max_cycles),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .busy(busy), .done(done), .aborted(aborted), .error(error),
        .bursts_done(bursts_done), .beats_total(beats_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int tmode    = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int launch_q[$];
    int fin_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Traffic patterns: 0 always, 1 random ready, 2 no valid, 3 random both, 4 toggling ready.
    always @(posedge clk) begin
        #1;
        case (tmode)
            0: begin mon_tvalid = 1'b1; mon_tready = 1'b1; end
            1: begin mon_tvalid = 1'b1; mon_tready = 1'($urandom_range(0, 1)); end
            2: begin mon_tvalid = 1'b0; mon_tready = 1'b1; end
            3: begin mon_tvalid = 1'($urandom_range(0, 1)); mon_tready = 1'($urandom_range(0, 1)); end
            default: begin mon_tvalid = 1'b1; mon_tready = ~mon_tready; end
        endcase
    end

    // Behavioural model: tracks beats left in the burst and gap cycles left.
    logic        m_busy = 0, m_launch = 0, m_done = 0, m_aborted = 0, m_error = 0;
    logic        m_in_run = 0, m_in_gap = 0;
    logic [31:0] m_bc = 0;
    logic [15:0] m_cnt = 0, m_gap = 0, m_bursts = 0;
    logic [47:0] m_total = 0;
    longint unsigned m_left = 0;
    int          m_gap_left = 0, m_quiet = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_launch = 0; m_done = 0; m_aborted = 0; m_error = 0;
            m_in_run = 0; m_in_gap = 0; m_bc = 0; m_cnt = 0; m_gap = 0;
            m_bursts = 0; m_total = 0; m_left = 0; m_gap_left = 0; m_quiet = 0;
        end else if (!m_busy) begin
            if (cfg_start) begin
                m_bc = cfg_burst_cycles; m_cnt = cfg_burst_count; m_gap = cfg_gap_cycles;
                m_bursts = 0; m_total = 0; m_aborted = 0; m_error = 0; m_busy = 1;
                if (m_bc == 0 || m_cnt == 0) m_done = 1;
                else m_launch = 1;
            end
        end else if (cfg_abort) begin
            m_busy = 0; m_aborted = 1; m_launch = 0; m_done = 0; m_in_run = 0; m_in_gap = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_launch) begin
            m_launch = 0; m_in_run = 1; m_left = m_bc; m_quiet = 0;
        end else if (m_in_run) begin
            if (mon_tvalid && mon_tready) begin
                m_total = m_total + 48'd1;
                m_left--;
                m_quiet = 0;
                if (m_left == 0) begin
                    m_bursts = m_bursts + 16'd1;
                    fin_q.push_back(cyc);
                    m_in_run = 0;
                    if (m_bursts == m_cnt) m_done = 1;
                    else begin
                        m_in_gap = 1;
                        m_gap_left = (m_gap == 0) ? 1 : int'(m_gap);
                    end
                end
            end else begin
                m_quiet++;
`ifdef GEN_SEQUENCER_TIMEOUT_EN
                if (m_quiet == int'(TB_TIMEOUT)) begin
                    m_error = 1; m_busy = 0; m_in_run = 0;
                end
`endif
            end
        end else if (m_in_gap) begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                m_in_gap = 0; m_launch = 1;
            end
        end
    end

    logic [100:0] dut_vec, exp_vec;
    assign dut_vec = {gen_start, busy, done, aborted, error, bursts_done, gen_max_cycles, beats_total};
    assign exp_vec = {m_launch, m_busy, m_done, m_aborted, m_error, m_bursts, m_bc, m_total};

    // Per-cycle comparison plus event logging for the directed checks.
    always @(negedge clk) begin
        check("cycle_outputs", 128'(dut_vec), 128'(exp_vec));
        if (resetn) begin
            if (gen_start) launch_q.push_back(cyc);
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic clear_log();
        launch_q.delete(); fin_q.delete(); done_cnt = 0;
    endtask

    task automatic start_run(input logic [31:0] bc, input logic [15:0] cnt, input logic [15:0] gap,
                             output int s);
        @(posedge clk); #1;
        cfg_burst_cycles = bc; cfg_burst_count = cnt; cfg_gap_cycles = gap;
        cfg_start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        // Scramble cfg after the start so a latched copy is required.
        cfg_burst_cycles = 32'($urandom_range(1, 9));
        cfg_burst_count  = 16'($urandom_range(0, 9));
        cfg_gap_cycles   = 16'($urandom_range(0, 9));
    endtask

    task automatic wait_idle(input string name, output int t);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (!busy) begin t = cyc; return; end
        end
        check({name, "_idle_timeout"}, 128'(busy), 128'(0));
        t = cyc;
    endtask

    initial begin
        int s, t, k;
        resetn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_burst_cycles = '0; cfg_burst_count = '0; cfg_gap_cycles = '0;
        mon_tvalid = 1'b0; mon_tready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 128'(dut_vec), 128'(0));
        @(posedge clk); #1 resetn = 1'b1;

        // Three bursts of five beats with a two-cycle gap, always ready.
        tmode = 0; clear_log();
        start_run(32'd5, 16'd3, 16'd2, s);
        wait_idle("basic", t);
        check("basic_launches", 128'(launch_q.size()), 128'(3));
        if (launch_q.size() == 3)
            check("basic_cycles_between_launch", 128'(launch_q[1] - launch_q[0] - 1), 128'(7));
        check("basic_done_count", 128'(done_cnt), 128'(1));
        check("basic_bursts_done", 128'(bursts_done), 128'(3));
        check("basic_beats_total", 128'(beats_total), 128'(15));

        // Zero burst count finishes straight away.
        clear_log();
        start_run(32'd5, 16'd0, 16'd2, s);
        wait_idle("zero_count", t);
        check("zero_launches", 128'(launch_q.size()), 128'(0));
        check("zero_done_count", 128'(done_cnt), 128'(1));
        check("zero_done_cycle_from_start", 128'(done_cyc - s + 1), 128'(2));
        check("zero_beats_total", 128'(beats_total), 128'(0));

        // Toggling ready, two bursts of four, no gap.
        tmode = 4; clear_log();
        start_run(32'd4, 16'd2, 16'd0, s);
        wait_idle("toggle", t);
        check("toggle_beats_total", 128'(beats_total), 128'(8));
        check("toggle_bursts_done", 128'(bursts_done), 128'(2));
        if (launch_q.size() == 2 && fin_q.size() >= 1)
            check("toggle_cycles_beat_to_launch", 128'(launch_q[1] - fin_q[0] - 1), 128'(1));
        else
            check("toggle_launch_count", 128'(launch_q.size()), 128'(2));

        // Abort during the second burst.
        tmode = 0; clear_log();
        start_run(32'd5, 16'd3, 16'd2, s);
        for (k = 0; k < 200 && launch_q.size() < 2; k++) begin @(negedge clk); #1; end
        check("abort_second_launch_seen", 128'(launch_q.size()), 128'(2));
        @(posedge clk); #1 cfg_abort = 1'b1;
        @(posedge clk); #1 cfg_abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_flag", 128'(aborted), 128'(1));
        check("abort_bursts_held", 128'(bursts_done), 128'(1));
        repeat (3) @(negedge clk);
        check("abort_no_done", 128'(done_cnt), 128'(0));
        start_run(32'd2, 16'd1, 16'd0, s);
        @(negedge clk);
        check("abort_cleared_by_start", 128'(aborted), 128'(0));
        wait_idle("after_abort", t);

`ifdef GEN_SEQUENCER_TIMEOUT_EN
        // Watchdog: no valid during RUN.
        tmode = 2; clear_log();
        start_run(32'd4, 16'd1, 16'd0, s);
        wait_idle("timeout", t);
        check("timeout_error", 128'(error), 128'(1));
        check("timeout_no_done", 128'(done_cnt), 128'(0));
        if (launch_q.size() == 1)
            check("timeout_cycles_launch_to_idle", 128'(t - launch_q[0]), 128'(TB_TIMEOUT + 1));
        tmode = 0;
`endif

        // Reset asserted in the middle of a gap.
        tmode = 0; clear_log();
        start_run(32'd3, 16'd3, 16'd6, s);
        for (k = 0; k < 200 && !m_in_gap; k++) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b0;
        #1 check("midgap_reset_outputs", 128'(dut_vec), 128'(0));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        clear_log();
        start_run(32'd2, 16'd2, 16'd1, s);
        wait_idle("post_reset", t);
        check("post_reset_beats_total", 128'(beats_total), 128'(4));
        check("post_reset_done_count", 128'(done_cnt), 128'(1));

        // Random runs with cfg noise, ignored starts and occasional aborts.
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0: tmode = 0;
                1: tmode = 1;
                2: tmode = 3;
                default: tmode = 4;
            endcase
            start_run(32'($urandom_range(0, 6)), 16'($urandom_range(0, 3)),
                      16'($urandom_range(0, 3)), s);
            for (k = 0; k < 200 && busy; k++) begin
                @(posedge clk); #1;
                cfg_burst_cycles = 32'($urandom_range(0, 6));
                cfg_burst_count  = 16'($urandom_range(0, 3));
                cfg_gap_cycles   = 16'($urandom_range(0, 3));
                cfg_start = busy && ($urandom_range(0, 7) == 0);
                cfg_abort = ($urandom_range(0, 79) == 0);
            end
            @(posedge clk); #1 cfg_start = 1'b0; cfg_abort = 1'b0;
            wait_idle("random", t);
            @(posedge clk); #1 cfg_abort = 1'b1;
            @(posedge clk); #1 cfg_abort = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
